// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin two-port sequencer for a single-port word data memory
module data_mem_arbiter #(
    parameter int N             = 32,
    parameter int ACCESS_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_i,
    input  logic         req1_i,
    input  logic         we0_i,
    input  logic         we1_i,
    input  logic [N-1:0] adr0_i,
    input  logic [N-1:0] adr1_i,
    input  logic [N-1:0] wd0_i,
    input  logic [N-1:0] wd1_i,
    output logic         gnt0_o,
    output logic         gnt1_o,
    output logic         rv0_o,
    output logic         rv1_o,
    output logic [N-1:0] rd0_o,
    output logic [N-1:0] rd1_o,
    output logic         err0_o,
    output logic         err1_o,
    output logic [N-1:0] mem_adr_o,
    output logic [N-1:0] write_data_o,
    output logic         mem_write_o,
    input  logic [N-1:0] read_data_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state_q;
    logic           ptr_q;
    logic           port_q;
    logic           we_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]   mem_adr_q;
    logic [N-1:0]   write_data_q;
    logic [N-1:0]   rd0_q;
    logic [N-1:0]   rd1_q;
    logic           rv0_q;
    logic           rv1_q;
    logic           err0_q;
    logic           err1_q;

    logic           any_req;
    logic           pick1;
    logic           win_we;
    logic [N-1:0]   win_adr;
    logic [N-1:0]   win_wd;
    logic           misaligned;
    logic           last_cycle;

    // Port 1 wins when it is the only requester, or both request and the pointer favours it.
    assign any_req    = req0_i | req1_i;
    assign pick1      = req1_i & (~req0_i | ptr_q);
    assign win_we     = pick1 ? we1_i  : we0_i;
    assign win_adr    = pick1 ? adr1_i : adr0_i;
    assign win_wd     = pick1 ? wd1_i  : wd0_i;
    assign misaligned = |win_adr[1:0];
    assign last_cycle = (cnt_q == CNT_W'(ACCESS_CYCLES - 1));

    assign gnt0_o       = (state_q == IDLE) & req0_i & ~pick1;
    assign gnt1_o       = (state_q == IDLE) & pick1;
    assign mem_write_o  = (state_q == ACCESS) & last_cycle & we_q;
    assign mem_adr_o    = mem_adr_q;
    assign write_data_o = write_data_q;
    assign rv0_o        = rv0_q;
    assign rv1_o        = rv1_q;
    assign err0_o       = err0_q;
    assign err1_o       = err1_q;
    assign rd0_o        = rd0_q;
    assign rd1_o        = rd1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            mem_adr_q    <= '0;
            write_data_q <= '0;
            rd0_q        <= '0;
            rd1_q        <= '0;
            rv0_q        <= 1'b0;
            rv1_q        <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            rv0_q  <= 1'b0;
            rv1_q  <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        port_q <= pick1;
                        we_q   <= win_we;
                        cnt_q  <= '0;
                        if (misaligned) begin
                            // Rejected access: answer next cycle, memory port untouched.
                            state_q <= DONE;
                            rv0_q   <= ~pick1;
                            rv1_q   <= pick1;
                            err0_q  <= ~pick1;
                            err1_q  <= pick1;
                        end else begin
                            state_q      <= ACCESS;
                            mem_adr_q    <= win_adr;
                            write_data_q <= win_wd;
                        end
                    end
                end
                ACCESS: begin
                    if (last_cycle) begin
                        if (!we_q) begin
                            if (port_q) rd1_q <= read_data_i;
                            else        rd0_q <= read_data_i;
                        end
                        state_q <= DONE;
                        rv0_q   <= ~port_q;
                        rv1_q   <= port_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    ptr_q   <= ~port_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter with a transaction-level reference model
module tb_data_mem_arbiter;

    localparam int AC = 3;

    typedef struct {
        int          due;
        bit          upd;
        bit          wr;
        bit          err;
        int          idx;
        logic [31:0] rd;
        logic [31:0] wd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rq [2];
    logic        wev [2];
    logic [31:0] ad [2];
    logic [31:0] wdv [2];

    logic        gnt0, gnt1, rv0, rv1, err0, err1, mem_write;
    logic [31:0] rd0, rd1, mem_adr, write_data, read_data;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    bit          mem_init = 1'b0;
    bit          ref_init = 1'b0;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sq [2][$];
    int          gcnt [2];
    int          glog [$];
    bit          ptr;
    int          next_free;
    bit          cur_al;
    int          cur_g;
    bit          cur_we;
    logic [31:0] cur_adr, cur_wd;
    logic [31:0] last_rd [2];
    int          wcount = 0;
    int          exp_writes = 0;

    data_mem_arbiter #(.N(32), .ACCESS_CYCLES(AC), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(rq[0]), .req1_i(rq[1]), .we0_i(wev[0]), .we1_i(wev[1]),
        .adr0_i(ad[0]), .adr1_i(ad[1]), .wd0_i(wdv[0]), .wd1_i(wdv[1]),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .rv0_o(rv0), .rv1_o(rv1),
        .rd0_o(rd0), .rd1_o(rd1), .err0_o(err0), .err1_o(err1),
        .mem_adr_o(mem_adr), .write_data_o(write_data), .mem_write_o(mem_write),
        .read_data_i(read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(input int i);
        if (i == 250) return 32'h1234_5678;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    assign read_data = mem[mem_adr[9:2]];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
            mem_init <= 1'b1;
        end else if (mem_write) begin
            mem[mem_adr[9:2]] <= write_data;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %08h expected %08h", name, cyc, act, exp);
        end
    endtask

    // Reference model: grant decisions, access window and expected responses per transaction.
    always @(negedge clk) begin
        if (!rst_n) begin
            sq[0].delete();
            sq[1].delete();
            ptr       = 1'b0;
            next_free = 0;
            cur_al    = 1'b0;
        end else begin
            if (cyc >= next_free && (rq[0] || rq[1])) begin
                int   w;
                bit   al;
                exp_t e;
                w  = (rq[0] && rq[1]) ? int'(ptr) : (rq[1] ? 1 : 0);
                chk("gnt0", 32'(gnt0), 32'(w == 0));
                chk("gnt1", 32'(gnt1), 32'(w == 1));
                al    = (ad[w][1:0] == 2'b00);
                e.due = cyc + (al ? AC + 1 : 1);
                e.err = !al;
                e.wr  = al && wev[w];
                e.upd = al && !wev[w];
                e.idx = int'(ad[w][9:2]);
                e.rd  = ref_mem[e.idx];
                e.wd  = wdv[w];
                sq[w].push_back(e);
                gcnt[w]++;
                glog.push_back(w);
                next_free = cyc + (al ? AC + 2 : 2);
                ptr       = (w == 0);
                if (al) begin
                    cur_al  = 1'b1;
                    cur_g   = cyc;
                    cur_adr = ad[w];
                    cur_wd  = wdv[w];
                    cur_we  = wev[w];
                end
            end else begin
                chk("gnt0_idle", 32'(gnt0), 32'd0);
                chk("gnt1_idle", 32'(gnt1), 32'd0);
            end
            if (cur_al && cyc > cur_g && cyc <= cur_g + AC) begin
                chk("mem_adr", mem_adr, cur_adr);
                chk("write_data", write_data, cur_wd);
                chk("mem_write", 32'(mem_write), 32'(cur_we && cyc == cur_g + AC));
            end else begin
                chk("mem_write_quiet", 32'(mem_write), 32'd0);
            end
        end
    end

    // Monitor: pops the scoreboard whenever a response appears.
    always @(negedge clk) begin
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
            ref_init = 1'b1;
        end
        if (!rst_n) begin
            last_rd[0] = '0;
            last_rd[1] = '0;
        end else begin
            if (mem_write) wcount++;
            for (int p = 0; p < 2; p++) begin
                logic        rv, er;
                logic [31:0] rd;
                exp_t        e;
                rv = p ? rv1 : rv0;
                er = p ? err1 : err0;
                rd = p ? rd1 : rd0;
                if (rv) begin
                    if (sq[p].size() == 0) begin
                        chk($sformatf("rv%0d_unexpected", p), 32'(rv), 32'd0);
                    end else begin
                        e = sq[p].pop_front();
                        chk($sformatf("rv%0d_latency", p), 32'(cyc), 32'(e.due));
                        chk($sformatf("err%0d", p), 32'(er), 32'(e.err));
                        chk($sformatf("rd%0d", p), rd, e.upd ? e.rd : last_rd[p]);
                        if (e.upd) last_rd[p] = e.rd;
                        if (e.wr) begin
                            ref_mem[e.idx] = e.wd;
                            exp_writes++;
                        end
                    end
                end else begin
                    if (sq[p].size() != 0 && sq[p][0].due <= cyc) begin
                        chk($sformatf("rv%0d_missing", p), 32'(rv), 32'd1);
                        void'(sq[p].pop_front());
                    end
                    chk($sformatf("rd%0d_held", p), rd, last_rd[p]);
                    chk($sformatf("err%0d_quiet", p), 32'(er), 32'd0);
                end
            end
        end
    end

    task automatic drive(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input bit may_drop);
        int g0;
        bit got;
        g0 = gcnt[p];
        got = 1'b0;
        rq[p] = 1'b1; wev[p] = w; ad[p] = a; wdv[p] = d;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (gcnt[p] != g0) begin
                got = 1'b1;
                break;
            end
            if (may_drop) break;
        end
        rq[p] = 1'b0; wev[p] = 1'($urandom); ad[p] = $urandom; wdv[p] = $urandom;
        if (!got && !may_drop) chk($sformatf("grant%0d_timeout", p), 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        repeat (AC + 4) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_adr(input bit allow_mis);
        logic [1:0] lo;
        lo = (allow_mis && $urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return {22'd0, 8'($urandom_range(240, 255)), lo};
    endfunction

    initial begin
        int          w0, base;
        logic [31:0] saved;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; wev[p] = 1'b0; ad[p] = '0; wdv[p] = '0; gcnt[p] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("rst_rv", 32'({rv0, rv1, err0, err1}), 32'd0);
        chk("rst_rd0", rd0, 32'd0);
        chk("rst_rd1", rd1, 32'd0);
        chk("rst_mem_adr", mem_adr, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        drive(0, 1'b0, 32'h3E8, 32'h0, 1'b0);
        wait_idle();
        chk("single_read_rd0", rd0, 32'h1234_5678);

        w0 = wcount;
        drive(1, 1'b1, 32'h3EC, 32'hDEAD_BEEF, 1'b0);
        wait_idle();
        drive(1, 1'b0, 32'h3EC, 32'h0, 1'b0);
        wait_idle();
        chk("wr_rd_pulses", 32'(wcount - w0), 32'd1);
        chk("wr_rd_rd1", rd1, 32'hDEAD_BEEF);
        chk("wr_rd_mem", mem[251], 32'hDEAD_BEEF);

        base = glog.size();
        fork
            for (int i = 0; i < 3; i++) drive(0, 1'b0, rnd_adr(1'b0), $urandom, 1'b0);
            for (int i = 0; i < 3; i++) drive(1, 1'b0, rnd_adr(1'b0), $urandom, 1'b0);
        join
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            if (glog.size() > base + i) chk($sformatf("alternate_%0d", i), 32'(glog[base + i]), 32'(i % 2));
            else chk($sformatf("alternate_%0d_missing", i), 32'd0, 32'd1);
        end

        w0 = wcount;
        saved = mem[250];
        drive(1, 1'b1, 32'h3E9, 32'hCAFE_F00D, 1'b0);
        wait_idle();
        chk("mis_pulses", 32'(wcount - w0), 32'd0);
        chk("mis_mem", mem[250], saved);

        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                drive(0, 1'($urandom), rnd_adr(1'b1), $urandom, $urandom_range(0, 7) == 0);
            end
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                drive(1, 1'($urandom), rnd_adr(1'b1), $urandom, $urandom_range(0, 7) == 0);
            end
        join
        wait_idle();

        saved = mem[64];
        w0 = gcnt[0];
        rq[0] = 1'b1; wev[0] = 1'b1; ad[0] = 32'h100; wdv[0] = 32'hA5A5_A5A5;
        for (int k = 0; k < 20 && gcnt[0] == w0; k++) begin
            @(posedge clk); #1;
        end
        rq[0] = 1'b0;
        chk("abort_granted", 32'(gcnt[0] - w0), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_rv", 32'({rv0, rv1}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_mem_unchanged", mem[64], saved);
        rst_n = 1'b1;
        base = glog.size();
        fork
            drive(0, 1'b0, rnd_adr(1'b0), $urandom, 1'b0);
            drive(1, 1'b0, rnd_adr(1'b0), $urandom, 1'b0);
        join
        wait_idle();
        if (glog.size() > base) chk("post_reset_first_gnt", 32'(glog[base]), 32'd0);
        else chk("post_reset_first_gnt_missing", 32'd0, 32'd1);

        chk("sq0_drained", 32'(sq[0].size()), 32'd0);
        chk("sq1_drained", 32'(sq[1].size()), 32'd0);
        chk("write_count", 32'(wcount), 32'(exp_writes));
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
            chk("mem_image", 32'(bad), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d: got 0 expected 1", cyc);
        $fatal(1);
    end

endmodule
